mem_stage_access: RTL and testbench

- MEM-stage access controller for the 5-stage pipeline. Consumes the EX/MEM register outputs and runs loads and stores against a req/ack data memory that may take several cycles.
- Asserts Stall, which freezes PC, IF/ID, ID/EX and EX/MEM while an access is outstanding.
- Contains the MEM/WB pipeline register and drives the write-back stage.

---
 rtl/mem_stage_access.sv | 115 +++++++++++
 tb/tb_mem_stage_access.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_access.sv
// MEM-stage access controller: issues loads/stores to a req/ack data memory,
// freezes the front of the pipeline while an access is outstanding, and holds MEM/WB.
module mem_stage_access #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALUResultIn,
  input  logic [31:0] ReadDataRF1In,
  input  logic [4:0]  WriteRegisterIn,
  input  logic        RegWriteIn,
  input  logic        MemReadIn,
  input  logic        MemWriteIn,
  input  logic        MemToRegIn,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  input  logic [31:0] MemRData,
  input  logic        MemAck,
  output logic        Stall,
  output logic        RegWrite,
  output logic        MemToReg,
  output logic [31:0] ReadData,
  output logic [31:0] ALUResult,
  output logic [4:0]  WriteRegister,
  output logic        Misalign,
  output logic        BusErr
);

  localparam logic [0:0]       ST_IDLE   = 1'b0;
  localparam logic [0:0]       ST_ACCESS = 1'b1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_memop;
  logic             w_aligned;
  logic             w_start;
  logic             w_last;

  assign w_memop   = MemReadIn | MemWriteIn;
  assign w_aligned = (ALUResultIn[1:0] == 2'b00);
  assign w_start   = w_memop & w_aligned;
  assign w_last    = (r_cnt == CNT_LAST);

  // In the timeout cycle the stall is released so the failing instruction retires.
  always_comb begin
    Stall = 1'b0;
    if (r_state == ST_IDLE) Stall = w_start;
    else                    Stall = !MemAck && !w_last;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      MemReq        <= 1'b0;
      MemWe         <= 1'b0;
      MemAddr       <= '0;
      MemWData      <= '0;
      RegWrite      <= 1'b0;
      MemToReg      <= 1'b0;
      ReadData      <= '0;
      ALUResult     <= '0;
      WriteRegister <= '0;
      Misalign      <= 1'b0;
      BusErr        <= 1'b0;
    end else begin
      // MEM/WB defaults to a bubble; only retiring instructions overwrite it.
      Misalign      <= 1'b0;
      BusErr        <= 1'b0;
      RegWrite      <= 1'b0;
      MemToReg      <= 1'b0;
      ReadData      <= '0;
      ALUResult     <= '0;
      WriteRegister <= '0;
      if (r_state == ST_IDLE) begin
        if (!w_memop) begin
          RegWrite      <= RegWriteIn;
          MemToReg      <= MemToRegIn;
          ALUResult     <= ALUResultIn;
          WriteRegister <= WriteRegisterIn;
        end else if (!w_aligned) begin
          Misalign <= 1'b1;
        end else begin
          r_state  <= ST_ACCESS;
          r_cnt    <= '0;
          MemReq   <= 1'b1;
          MemWe    <= MemWriteIn & ~MemReadIn;
          MemAddr  <= ALUResultIn;
          MemWData <= ReadDataRF1In;
        end
      end else begin
        if (MemAck) begin
          RegWrite      <= RegWriteIn;
          MemToReg      <= MemToRegIn;
          ALUResult     <= ALUResultIn;
          WriteRegister <= WriteRegisterIn;
          ReadData      <= MemWe ? '0 : MemRData;
          MemReq        <= 1'b0;
          r_state       <= ST_IDLE;
        end else if (w_last) begin
          BusErr  <= 1'b1;
          MemReq  <= 1'b0;
          r_state <= ST_IDLE;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_access.sv
// Bench for mem_stage_access: transaction-level model of the MEM stage with a
// stalling EX/MEM feeder and a variable-latency memory, plus directed scenarios.
module tb_mem_stage_access;
  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ALUResultIn, ReadDataRF1In, MemRData;
  logic [4:0]  WriteRegisterIn;
  logic        RegWriteIn, MemReadIn, MemWriteIn, MemToRegIn, MemAck;
  logic        MemReq, MemWe, Stall, RegWrite, MemToReg, Misalign, BusErr;
  logic [31:0] MemAddr, MemWData, ReadData, ALUResult;
  logic [4:0]  WriteRegister;

  mem_stage_access #(.TIMEOUT(TO), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .ALUResultIn(ALUResultIn), .ReadDataRF1In(ReadDataRF1In), .WriteRegisterIn(WriteRegisterIn),
    .RegWriteIn(RegWriteIn), .MemReadIn(MemReadIn), .MemWriteIn(MemWriteIn), .MemToRegIn(MemToRegIn),
    .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemRData(MemRData), .MemAck(MemAck), .Stall(Stall),
    .RegWrite(RegWrite), .MemToReg(MemToReg), .ReadData(ReadData), .ALUResult(ALUResult),
    .WriteRegister(WriteRegister), .Misalign(Misalign), .BusErr(BusErr)
  );

  always #5 clk = ~clk;

  // lat: cycles the memory waits in the access before acking (>= TO means never).
  // rst_idx: access cycle at which the bench asserts reset (-1 = never).
  typedef struct {
    logic [31:0] alu, rf1, rdata;
    logic [4:0]  wr;
    logic        rw, mr, mw, m2r, spur;
    int          lat, rst_idx;
  } instr_t;

  instr_t iq[$];
  instr_t cur;
  int errors = 0;
  int checks = 0;

  bit m_busy, adv, force_rst, rnd_spur;
  int m_idx;
  logic        e_req, e_we, e_rw, e_m2r, e_mis, e_berr, e_full, e_zero;
  logic [31:0] e_addr, e_wdata, e_rd, e_alu;
  logic [4:0]  e_wr;

  int n_stall, n_req, n_rise, n_mis, n_berr, n_rw;
  logic        prev_req, s_m2r, s_we;
  logic [31:0] s_rd, s_alu, s_addr, s_wdata;
  logic [4:0]  s_wr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic instr_t mk(input logic [31:0] alu, rf1, rdata, input logic [4:0] wr,
                                input logic rw, mr, mw, m2r, input int lat, rst_idx);
    instr_t t;
    t.alu = alu; t.rf1 = rf1; t.rdata = rdata; t.wr = wr;
    t.rw = rw; t.mr = mr; t.mw = mw; t.m2r = m2r; t.spur = 1'b0;
    t.lat = lat; t.rst_idx = rst_idx;
    return t;
  endfunction

  function automatic instr_t nop();
    return mk('0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1);
  endfunction

  task automatic step();
    logic        ack, rnow, xs;
    logic [31:0] rd;
    @(negedge clk);
    chk("MemReq", MemReq, e_req);
    if (e_req || e_zero) begin
      chk("MemWe", MemWe, e_we);
      chk("MemAddr", MemAddr, e_addr);
      chk("MemWData", MemWData, e_wdata);
    end
    chk("RegWrite", RegWrite, e_rw);
    chk("MemToReg", MemToReg, e_m2r);
    chk("Misalign", Misalign, e_mis);
    chk("BusErr", BusErr, e_berr);
    if (e_full) begin
      chk("ReadData", ReadData, e_rd);
      chk("ALUResult", ALUResult, e_alu);
      chk("WriteRegister", WriteRegister, e_wr);
    end
    n_req  += int'(MemReq);
    n_mis  += int'(Misalign);
    n_berr += int'(BusErr);
    if (MemReq && !prev_req) n_rise++;
    prev_req = MemReq;
    if (MemReq) begin s_addr = MemAddr; s_we = MemWe; s_wdata = MemWData; end
    if (RegWrite) begin
      n_rw++; s_rd = ReadData; s_alu = ALUResult; s_wr = WriteRegister; s_m2r = MemToReg;
    end

    if (adv) cur = (iq.size() > 0) ? iq.pop_front() : nop();
    rnow = force_rst || (m_busy && m_idx == cur.rst_idx);
    ack  = m_busy ? (m_idx == cur.lat) : (cur.spur || (rnd_spur && $urandom_range(3) == 0));
    rd   = (m_busy && ack) ? cur.rdata : $urandom;
    rst = rnow; ALUResultIn = cur.alu; ReadDataRF1In = cur.rf1; WriteRegisterIn = cur.wr;
    RegWriteIn = cur.rw; MemReadIn = cur.mr; MemWriteIn = cur.mw; MemToRegIn = cur.m2r;
    MemAck = ack; MemRData = rd;
    #1;
    xs = m_busy ? (!ack && m_idx != int'(TO) - 1) : ((cur.mr || cur.mw) && cur.alu[1:0] == 2'b00);
    chk("Stall", Stall, xs);
    n_stall += int'(Stall);

    if (rnow) begin
      m_busy = 0; m_idx = 0; adv = 1;
      e_req = 0; e_we = 0; e_addr = '0; e_wdata = '0; e_rw = 0; e_m2r = 0;
      e_rd = '0; e_alu = '0; e_wr = '0; e_mis = 0; e_berr = 0; e_full = 1; e_zero = 1;
    end else begin
      e_zero = 0; e_mis = 0; e_berr = 0; e_rw = 0; e_m2r = 0; e_full = 0;
      if (!m_busy) begin
        if (!(cur.mr || cur.mw)) begin
          e_rw = cur.rw; e_m2r = cur.m2r; e_alu = cur.alu; e_wr = cur.wr; e_rd = '0; e_full = 1;
        end else if (cur.alu[1:0] != 2'b00) begin
          e_mis = 1;
        end else begin
          m_busy = 1; m_idx = 0; e_req = 1;
          e_we = cur.mw && !cur.mr; e_addr = cur.alu; e_wdata = cur.rf1;
        end
      end else if (ack) begin
        e_rw = cur.rw; e_m2r = cur.m2r; e_alu = cur.alu; e_wr = cur.wr;
        e_rd = e_we ? 32'h0 : rd; e_full = 1; m_busy = 0; e_req = 0;
      end else if (m_idx == int'(TO) - 1) begin
        e_berr = 1; m_busy = 0; e_req = 0;
      end else begin
        m_idx++;
      end
      adv = !xs;
    end
  endtask

  task automatic run_seg(input string nm, input int budget);
    int n;
    n_stall = 0; n_req = 0; n_rise = 0; n_mis = 0; n_berr = 0; n_rw = 0; prev_req = 1'b0;
    n = 0;
    while ((iq.size() > 0 || m_busy || !adv) && n < budget) begin
      step();
      n++;
    end
    chk({nm, "_drained"}, 32'(n < budget), 32'd1);
    repeat (2) step();
  endtask

  initial begin
    instr_t t;
    instr_t sp;
    rst = 1'b1; ALUResultIn = '0; ReadDataRF1In = '0; WriteRegisterIn = '0;
    RegWriteIn = 0; MemReadIn = 0; MemWriteIn = 0; MemToRegIn = 0; MemAck = 0; MemRData = '0;
    m_busy = 0; m_idx = 0; adv = 1; force_rst = 1; rnd_spur = 0; cur = nop();
    e_req = 0; e_we = 0; e_addr = '0; e_wdata = '0; e_rw = 0; e_m2r = 0;
    e_rd = '0; e_alu = '0; e_wr = '0; e_mis = 0; e_berr = 0; e_full = 1; e_zero = 1;
    repeat (2) step();
    force_rst = 0;

    iq.push_back(mk(32'h1234, 32'h0, 32'h0, 5'd5, 1, 0, 0, 0, 0, -1));
    run_seg("alu", 50);
    chk("alu_stall", n_stall, 0); chk("alu_rw", n_rw, 1);
    chk("alu_result", s_alu, 32'h1234); chk("alu_wr", s_wr, 5); chk("alu_rd", s_rd, 0);

    iq.push_back(mk(32'h40, 32'h0BAD0BAD, 32'hDEADBEEF, 5'd7, 1, 1, 0, 1, 3, -1));
    run_seg("load", 50);
    chk("load_stall", n_stall, 4); chk("load_req", n_req, 4); chk("load_rise", n_rise, 1);
    chk("load_addr", s_addr, 32'h40); chk("load_we", s_we, 0); chk("load_rw", n_rw, 1);
    chk("load_m2r", s_m2r, 1); chk("load_rd", s_rd, 32'hDEADBEEF);

    iq.push_back(mk(32'h80, 32'hCAFE0001, 32'h0, 5'd3, 0, 0, 1, 0, 1, -1));
    run_seg("store", 50);
    chk("store_stall", n_stall, 2); chk("store_rise", n_rise, 1); chk("store_we", s_we, 1);
    chk("store_wdata", s_wdata, 32'hCAFE0001); chk("store_rw", n_rw, 0);

    iq.push_back(mk(32'h42, 32'h0, 32'h0, 5'd4, 1, 1, 0, 1, 0, -1));
    run_seg("misal", 50);
    chk("misal_pulse", n_mis, 1); chk("misal_req", n_req, 0);
    chk("misal_stall", n_stall, 0); chk("misal_rw", n_rw, 0);

    iq.push_back(mk(32'h60, 32'h0, 32'h0, 5'd6, 1, 1, 0, 1, 99, -1));
    run_seg("tmo", 50);
    chk("tmo_req", n_req, 4); chk("tmo_stall", n_stall, 4);
    chk("tmo_berr", n_berr, 1); chk("tmo_rw", n_rw, 0);

    iq.push_back(mk(32'h70, 32'h11111111, 32'h22222222, 5'd8, 1, 1, 1, 1, 0, -1));
    run_seg("rdwr", 50);
    chk("rdwr_we", s_we, 0); chk("rdwr_rd", s_rd, 32'h22222222); chk("rdwr_rw", n_rw, 1);

    iq.push_back(mk(32'h100, 32'h0, 32'h0, 5'd2, 1, 1, 0, 1, 99, 2));
    sp = nop(); sp.spur = 1'b1;
    iq.push_back(sp);
    iq.push_back(mk(32'h104, 32'h0, 32'h5A5A5A5A, 5'd9, 1, 1, 0, 1, 2, -1));
    run_seg("rstmid", 50);
    chk("rstmid_req", n_req, 6); chk("rstmid_rise", n_rise, 2); chk("rstmid_stall", n_stall, 7);
    chk("rstmid_berr", n_berr, 0); chk("rstmid_rw", n_rw, 1); chk("rstmid_rd", s_rd, 32'h5A5A5A5A);

    iq.push_back(mk(32'h200, 32'h0, 32'h1, 5'd1, 1, 1, 0, 1, 0, -1));
    iq.push_back(mk(32'h204, 32'h0, 32'h2, 5'd2, 1, 1, 0, 1, 0, -1));
    run_seg("b2b", 50);
    chk("b2b_rise", n_rise, 2); chk("b2b_req", n_req, 2); chk("b2b_stall", n_stall, 2);
    chk("b2b_rw", n_rw, 2);

    rnd_spur = 1;
    for (int i = 0; i < 400; i++) begin
      t = mk($urandom, $urandom, $urandom, 5'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom), int'($urandom_range(0, 5)), -1);
      if ($urandom_range(2) == 0) begin t.mr = 0; t.mw = 0; end
      if ($urandom_range(3) != 0) t.alu[1:0] = 2'b00;
      if ($urandom_range(19) == 0) t.rst_idx = int'($urandom_range(0, 3));
      iq.push_back(t);
    end
    run_seg("random", 20000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
